// File: rtl/ifetch_miss_queue_pkg.sv
// ifetch_miss_queue_pkg
// Shared types for the instruction-fetch miss queue: entry index, cache-line
// address and the per-entry state record. THREADS_PER_CORE falls back to 4
// when the core configuration does not provide it.

`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif

package ifetch_miss_queue_pkg;

  localparam int IMQ_ENTRIES     = `THREADS_PER_CORE;
  localparam int IMQ_LINE_ADDR_W = 26;
  localparam int IMQ_IDX_W       = $clog2(IMQ_ENTRIES);

  typedef logic [IMQ_IDX_W-1:0]       imq_entry_idx_t;
  typedef logic [IMQ_LINE_ADDR_W-1:0] cache_line_addr_t;
  typedef logic [IMQ_ENTRIES-1:0]     imq_thread_bitmap_t;

  typedef struct packed {
    logic               valid;
    logic               sent;
    cache_line_addr_t   addr;
    imq_thread_bitmap_t threads;
  } imq_entry_t;

  function automatic imq_thread_bitmap_t imq_thread_oh(input imq_entry_idx_t thread_idx);
    imq_thread_bitmap_t oh;
    oh             = '0;
    oh[thread_idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ifetch_miss_queue_arb.sv
// Shared arbitration helpers used by the miss queue.
//
// rr_arbiter: round-robin arbiter. Grants the first requester above the most
//   recently loaded index, wrapping to the lowest requester. The priority
//   pointer only moves when update_lru is high.
//   clk, reset (async, active-high), request[NUM_REQS], update_lru,
//   grant_oh[NUM_REQS] (combinational one-hot).
//
// oh_to_idx: one-hot to binary index encoder.
//   one_hot[NUM_SIGNALS] in, index[IDX_W] out.

module oh_to_idx #(
  parameter int NUM_SIGNALS = 4,
  parameter int IDX_W       = $clog2(NUM_SIGNALS)
) (
  input  logic [NUM_SIGNALS-1:0] one_hot,
  output logic [IDX_W-1:0]       index
);

  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      if (one_hot[i]) index = index | IDX_W'(i);
    end
  end

endmodule

module rr_arbiter #(
  parameter int NUM_REQS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] request,
  input  logic                update_lru,
  output logic [NUM_REQS-1:0] grant_oh
);

  localparam int IDX_W = $clog2(NUM_REQS);

  logic [IDX_W-1:0]    r_last_idx;
  logic [IDX_W-1:0]    w_grant_idx;
  logic [NUM_REQS-1:0] w_above;
  logic [NUM_REQS-1:0] w_hi_req;
  logic [NUM_REQS-1:0] w_pick_from;

  // Requesters strictly above the last winner get first pick; otherwise wrap.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      w_above[i] = (IDX_W'(i) > r_last_idx);
    end
    w_hi_req    = request & w_above;
    w_pick_from = (|w_hi_req) ? w_hi_req : request;
    grant_oh    = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (w_pick_from[i]) begin
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
      end
    end
  end

  oh_to_idx #(
    .NUM_SIGNALS (NUM_REQS),
    .IDX_W       (IDX_W)
  ) u_grant_enc (
    .one_hot (grant_oh),
    .index   (w_grant_idx)
  );

  // Pointer starts at the top so the very first grant goes to entry 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_idx <= IDX_W'(NUM_REQS - 1);
    end else if (update_lru && (|request)) begin
      r_last_idx <= w_grant_idx;
    end
  end

endmodule

// File: rtl/ifetch_miss_queue.sv
// ifetch_miss_queue
// Tracks outstanding L1 instruction-cache misses, issues one L2 request per
// queued line through a registered valid/ready port, and pulses the
// per-thread wake bitmap when a fill completes.
//
// Optional feature macro: ICACHE_MISS_MERGE_EN
//   defined   - misses to a line already queued merge into that entry, and a
//               miss to the line being filled this cycle joins its wake pulse.
//   undefined - every miss gets its own entry and its own L2 request.
//
// Ports:
//   clk, reset (async, active-high)
//   ifd_cache_miss / _paddr / _thread_idx : miss from the fetch data stage
//   imq_l2_req_valid/addr/id, l2_imq_req_ready : request to L2 (held until ready)
//   l2_imq_resp_valid / l2_imq_resp_id   : fill completion for an entry
//   imq_wake_bitmap                      : one-cycle wake pulse per thread
//   imq_full                             : all entries occupied
//
// NUM_THREADS and LINE_ADDR_WIDTH must match the package configuration since
// entry storage uses the shared imq_entry_t record.

module ifetch_miss_queue
  import ifetch_miss_queue_pkg::*;
#(
  parameter int NUM_THREADS     = IMQ_ENTRIES,
  parameter int LINE_ADDR_WIDTH = IMQ_LINE_ADDR_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ifd_cache_miss,
  input  logic [LINE_ADDR_WIDTH-1:0]     ifd_cache_miss_paddr,
  input  logic [$clog2(NUM_THREADS)-1:0] ifd_cache_miss_thread_idx,
  output logic                           imq_l2_req_valid,
  input  logic                           l2_imq_req_ready,
  output logic [LINE_ADDR_WIDTH-1:0]     imq_l2_req_addr,
  output logic [$clog2(NUM_THREADS)-1:0] imq_l2_req_id,
  input  logic                           l2_imq_resp_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] l2_imq_resp_id,
  output logic [NUM_THREADS-1:0]         imq_wake_bitmap,
  output logic                           imq_full
);

  localparam int IDX_W = $clog2(NUM_THREADS);

  imq_entry_t               r_entries [NUM_THREADS];
  imq_entry_t               w_entries_n [NUM_THREADS];
  logic                     r_req_valid;
  cache_line_addr_t         r_req_addr;
  imq_entry_idx_t           r_req_id;
  imq_thread_bitmap_t       r_wake;

  imq_entry_t               w_resp_entry;
  imq_thread_bitmap_t       w_miss_oh;
  imq_thread_bitmap_t       w_waiting;
  logic [NUM_THREADS-1:0]   w_valid;
  logic [NUM_THREADS-1:0]   w_pending;
  logic [NUM_THREADS-1:0]   w_match;
  logic                     w_merge;
  logic                     w_bypass;
  logic                     w_alloc;
  imq_entry_idx_t           w_free_idx;
  logic [NUM_THREADS-1:0]   w_alloc_oh;
  logic [NUM_THREADS-1:0]   w_arb_req;
  logic [NUM_THREADS-1:0]   w_grant_oh;
  imq_entry_idx_t           w_grant_idx;
  logic                     w_load;
  logic                     w_load_new;
  cache_line_addr_t         w_load_addr;
  imq_thread_bitmap_t       w_wake_n;

  always_comb begin
    w_miss_oh    = imq_thread_oh(ifd_cache_miss_thread_idx);
    w_resp_entry = r_entries[l2_imq_resp_id];
    w_waiting    = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_valid[i]   = r_entries[i].valid;
      w_pending[i] = r_entries[i].valid && !r_entries[i].sent;
      if (r_entries[i].valid) w_waiting = w_waiting | r_entries[i].threads;
    end
  end

`ifdef ICACHE_MISS_MERGE_EN
  // An entry being freed this cycle is handled by the bypass path, not merged.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_match[i] = r_entries[i].valid && (r_entries[i].addr == ifd_cache_miss_paddr) &&
                   !(l2_imq_resp_valid && (l2_imq_resp_id == IDX_W'(i)));
    end
    w_bypass = ifd_cache_miss && l2_imq_resp_valid && w_resp_entry.valid &&
               (w_resp_entry.addr == ifd_cache_miss_paddr);
  end
`else
  always_comb begin
    w_match  = '0;
    w_bypass = 1'b0;
  end
`endif

  // Lowest-index free entry; nothing is allocated if the queue is full.
  always_comb begin
    w_merge    = ifd_cache_miss && (|w_match);
    w_alloc    = ifd_cache_miss && !w_merge && !w_bypass && !(&w_valid);
    w_free_idx = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (!w_valid[i]) w_free_idx = IDX_W'(i);
    end
    w_alloc_oh = w_alloc ? imq_thread_oh(w_free_idx) : '0;
  end

  // The entry being allocated competes immediately so a miss can reach the
  // output register on the same edge that creates its entry.
  assign w_arb_req = w_pending | w_alloc_oh;
  assign w_load    = (|w_arb_req) && (!r_req_valid || l2_imq_req_ready);

  rr_arbiter #(
    .NUM_REQS (NUM_THREADS)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .request    (w_arb_req),
    .update_lru (w_load),
    .grant_oh   (w_grant_oh)
  );

  oh_to_idx #(
    .NUM_SIGNALS (NUM_THREADS),
    .IDX_W       (IDX_W)
  ) u_grant_enc (
    .one_hot (w_grant_oh),
    .index   (w_grant_idx)
  );

  always_comb begin
    w_load_new  = w_load && (|(w_grant_oh & w_alloc_oh));
    w_load_addr = w_load_new ? ifd_cache_miss_paddr : r_entries[w_grant_idx].addr;
  end

  always_comb begin
    w_entries_n = r_entries;
    if (w_load && !w_load_new) w_entries_n[w_grant_idx].sent = 1'b1;
    if (l2_imq_resp_valid) w_entries_n[l2_imq_resp_id] = '0;
    if (w_merge) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (w_match[i]) w_entries_n[i].threads = w_entries_n[i].threads | w_miss_oh;
      end
    end
    if (w_alloc) begin
      w_entries_n[w_free_idx] = '{valid: 1'b1, sent: w_load_new,
                                  addr: ifd_cache_miss_paddr, threads: w_miss_oh};
    end
  end

  // A bypassed miss joins the wake pulse of the line filled this cycle.
  always_comb begin
    w_wake_n = '0;
    if (l2_imq_resp_valid) begin
      w_wake_n = w_resp_entry.threads | (w_bypass ? w_miss_oh : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) r_entries[i] <= '0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_id    <= '0;
      r_wake      <= '0;
    end else begin
      r_entries <= w_entries_n;
      r_wake    <= w_wake_n;
      if (w_load) begin
        r_req_valid <= 1'b1;
        r_req_addr  <= w_load_addr;
        r_req_id    <= w_grant_idx;
      end else if (l2_imq_req_ready) begin
        r_req_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ifd_cache_miss) begin
        assert (!(&w_valid));
        assert ((w_waiting & w_miss_oh) == '0);
      end
      if (l2_imq_resp_valid) begin
        assert (w_resp_entry.valid && w_resp_entry.sent);
      end
    end
  end

  assign imq_l2_req_valid = r_req_valid;
  assign imq_l2_req_addr  = r_req_addr;
  assign imq_l2_req_id    = r_req_id;
  assign imq_wake_bitmap  = r_wake;
  assign imq_full         = &w_valid;

endmodule

// File: tb/tb_ifetch_miss_queue.sv
// Directed testbench for ifetch_miss_queue (4 threads, 26-bit line address).
// Expected values are hand-derived; merge/bypass expectations depend on
// whether ICACHE_MISS_MERGE_EN is defined for the build.

module tb_ifetch_miss_queue;

  logic        clk;
  logic        reset;
  logic        miss;
  logic [25:0] maddr;
  logic [1:0]  mthr;
  logic        req_valid;
  logic        ready;
  logic [25:0] req_addr;
  logic [1:0]  req_id;
  logic        rvalid;
  logic [1:0]  rid;
  logic [3:0]  wake;
  logic        full;

  int n_checks = 0;
  int n_fail   = 0;

  ifetch_miss_queue dut (
    .clk                       (clk),
    .reset                     (reset),
    .ifd_cache_miss            (miss),
    .ifd_cache_miss_paddr      (maddr),
    .ifd_cache_miss_thread_idx (mthr),
    .imq_l2_req_valid          (req_valid),
    .l2_imq_req_ready          (ready),
    .imq_l2_req_addr           (req_addr),
    .imq_l2_req_id             (req_id),
    .l2_imq_resp_valid         (rvalid),
    .l2_imq_resp_id            (rid),
    .imq_wake_bitmap           (wake),
    .imq_full                  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [1:0] thr, input logic [25:0] a);
    miss  = 1'b1;
    mthr  = thr;
    maddr = a;
    tick();
    miss  = 1'b0;
  endtask

  task automatic do_resp(input logic [1:0] id);
    rvalid = 1'b1;
    rid    = id;
    tick();
    rvalid = 1'b0;
  endtask

  task automatic check_req(input string tag, input logic v, input logic [1:0] id, input logic [25:0] a);
    check_eq(tag, {3'b0, req_valid, req_id, req_addr}, {3'b0, v, id, a});
  endtask

  initial begin
    reset  = 1'b1;
    miss   = 1'b0;
    maddr  = '0;
    mthr   = '0;
    ready  = 1'b0;
    rvalid = 1'b0;
    rid    = '0;

    // Reset state
    repeat (2) tick();
    check_eq("rst_valid", req_valid, 0);
    check_eq("rst_addr", req_addr, 0);
    check_eq("rst_id", req_id, 0);
    check_eq("rst_wake", wake, 0);
    check_eq("rst_full", full, 0);
    reset = 1'b0;
    tick();

    // Single miss with ready held high
    ready = 1'b1;
    do_miss(2'd1, 26'h12345);
    check_req("single_req", 1'b1, 2'd0, 26'h12345);
    tick();
    check_eq("single_accepted", req_valid, 0);
    do_resp(2'd0);
    check_eq("single_wake", wake, 4'b0010);
    tick();
    check_eq("single_wake_clr", wake, 0);

    // Two threads missing the same line
    ready = 1'b0;
    do_miss(2'd0, 26'h00040);
    check_req("merge_req0", 1'b1, 2'd0, 26'h00040);
    do_miss(2'd2, 26'h00040);
    check_req("merge_hold", 1'b1, 2'd0, 26'h00040);
    ready = 1'b1;
    tick();
`ifdef ICACHE_MISS_MERGE_EN
    check_eq("merge_single_req", req_valid, 0);
    ready = 1'b0;
    do_resp(2'd0);
    check_eq("merge_wake", wake, 4'b0101);
`else
    check_req("nomerge_req1", 1'b1, 2'd1, 26'h00040);
    tick();
    check_eq("nomerge_done", req_valid, 0);
    ready = 1'b0;
    do_resp(2'd0);
    check_eq("nomerge_wake0", wake, 4'b0001);
    do_resp(2'd1);
    check_eq("nomerge_wake1", wake, 4'b0100);
`endif
    tick();
    check_eq("merge_wake_clr", wake, 0);

    // Backpressure: request held for 10 cycles
    do_miss(2'd0, 26'h00100);
    do_miss(2'd1, 26'h00200);
    for (int i = 0; i < 10; i++) begin
      check_req("bp_hold", 1'b1, 2'd0, 26'h00100);
      tick();
    end
    ready = 1'b1;
    tick();
    check_req("bp_next", 1'b1, 2'd1, 26'h00200);
    tick();
    check_eq("bp_drained", req_valid, 0);
    do_resp(2'd0);
    check_eq("bp_wake0", wake, 4'b0001);
    do_resp(2'd1);
    check_eq("bp_wake1", wake, 4'b0010);

    // Miss to the line being filled in the same cycle
    do_miss(2'd0, 26'h00777);
    check_req("byp_req", 1'b1, 2'd0, 26'h00777);
    tick();
    check_eq("byp_accepted", req_valid, 0);
    miss   = 1'b1;
    mthr   = 2'd3;
    maddr  = 26'h00777;
    rvalid = 1'b1;
    rid    = 2'd0;
    tick();
    miss   = 1'b0;
    rvalid = 1'b0;
`ifdef ICACHE_MISS_MERGE_EN
    check_eq("byp_wake", wake, 4'b1001);
    check_eq("byp_no_req", req_valid, 0);
    tick();
    check_eq("byp_no_req2", req_valid, 0);
    check_eq("byp_full", full, 0);
`else
    check_eq("nobyp_wake", wake, 4'b0001);
    check_req("nobyp_req", 1'b1, 2'd1, 26'h00777);
    tick();
    check_eq("nobyp_accepted", req_valid, 0);
    do_resp(2'd1);
    check_eq("nobyp_wake3", wake, 4'b1000);
`endif

    // Four distinct lines, then out-of-order fills
    ready = 1'b0;
    do_miss(2'd0, 26'h01000);
    check_req("rr_req0", 1'b1, 2'd0, 26'h01000);
    do_miss(2'd1, 26'h02000);
    do_miss(2'd2, 26'h03000);
    check_eq("rr_not_full", full, 0);
    do_miss(2'd3, 26'h04000);
    check_eq("rr_full", full, 1);
    ready = 1'b1;
    tick();
    check_req("rr_req1", 1'b1, 2'd1, 26'h02000);
    tick();
    check_req("rr_req2", 1'b1, 2'd2, 26'h03000);
    tick();
    check_req("rr_req3", 1'b1, 2'd3, 26'h04000);
    tick();
    check_eq("rr_drained", req_valid, 0);
    do_resp(2'd2);
    check_eq("ooo_wake2", wake, 4'b0100);
    check_eq("ooo_full_clr", full, 0);
    do_resp(2'd0);
    check_eq("ooo_wake0", wake, 4'b0001);
    do_resp(2'd3);
    check_eq("ooo_wake3", wake, 4'b1000);
    do_resp(2'd1);
    check_eq("ooo_wake1", wake, 4'b0010);
    tick();
    check_eq("ooo_wake_clr", wake, 0);

    // Reset in the middle of traffic
    ready = 1'b0;
    do_miss(2'd0, 26'h05000);
    do_miss(2'd1, 26'h06000);
    check_req("mid_req", 1'b1, 2'd0, 26'h05000);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", req_valid, 0);
    check_eq("mid_rst_addr", req_addr, 0);
    check_eq("mid_rst_id", req_id, 0);
    check_eq("mid_rst_wake", wake, 0);
    check_eq("mid_rst_full", full, 0);
    tick();
    tick();
    reset = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("post_rst_valid", req_valid, 0);
      check_eq("post_rst_wake", wake, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_miss_queue.md
# ifetch_miss_queue

Tracks outstanding L1 instruction-cache misses between the instruction fetch data stage and the L1/L2 interface. It merges concurrent misses from different threads to the same cache line and issues one request per unique line to L2 via a valid/ready handshake. When the fill response returns, it produces the per-thread wake bitmap that clears the fetch stage's icache wait state.

## Interface
Parameters:
- NUM_THREADS, default `THREADS_PER_CORE: hardware threads per core; also the number of queue entries.
- LINE_ADDR_WIDTH, default 26: width of a physical cache-line address (paddr[31:6]).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ifd_cache_miss  in  1  icache miss detected this cycle.
- ifd_cache_miss_paddr  in  LINE_ADDR_WIDTH  physical line address of the miss.
- ifd_cache_miss_thread_idx  in  $clog2(NUM_THREADS)  thread that missed.
- imq_l2_req_valid  out  1  request to L2 pending.
- l2_imq_req_ready  in  1  L2 accepts the request this cycle.
- imq_l2_req_addr  out  LINE_ADDR_WIDTH  line address requested.
- imq_l2_req_id  out  $clog2(NUM_THREADS)  entry index tag carried with the request.
- l2_imq_resp_valid  in  1  fill for entry l2_imq_resp_id has completed (tags written).
- l2_imq_resp_id  in  $clog2(NUM_THREADS)  entry index of the completed fill.
- imq_wake_bitmap  out  NUM_THREADS  one-cycle pulse; threads whose miss is filled.
- imq_full  out  1  all entries valid (debug/perf only).

## Operation
- Each entry holds: valid, sent, line address, waiting-thread bitmap.
- Miss accept: if ICACHE_MISS_MERGE_EN and a valid entry matches the address, OR the thread bit into that entry. Otherwise allocate the lowest-index free entry with valid=1, sent=0, bitmap = one-hot(thread).
- Each thread has at most one outstanding miss, so a free entry always exists. A miss while imq_full=1, or from a thread already in some bitmap, is an assertion failure.
- Issue: rr_arbiter selects among entries with valid && !sent. The selected entry is loaded into the output register when the register is empty or being accepted. The arbiter LRU updates only on load.
- Handshake: imq_l2_req_valid/addr/id are held stable until l2_imq_req_ready. The entry's sent bit is set when the request is loaded.
- Response: the entry named by l2_imq_resp_id is freed. imq_wake_bitmap is set to its bitmap for exactly one cycle. A response naming an invalid or unsent entry is an assertion failure.
- Same-cycle miss and response to the same address: the missing thread bit is ORed into that cycle's wake bitmap and no entry is allocated, since the line is now resident. With merge disabled, a new entry is allocated instead.
- Same-cycle miss and response to different entries: both take effect; the freed entry is reusable the next cycle.

## Timing
- Reset values: imq_l2_req_valid=0, imq_l2_req_addr=0, imq_l2_req_id=0, imq_wake_bitmap=0, imq_full=0; all entries invalid.
- Miss at cycle N: entry visible at N+1; imq_l2_req_valid asserted at N+1 at earliest (registered output).
- Request accepted at cycle R (valid && ready): next request may be presented at R+1 (back-to-back, one per cycle).
- Response at cycle M: imq_wake_bitmap pulse at M+1; entry free at M+1.
- Reset mid-operation: all entries and the output request are dropped immediately. No wake is issued.

## Configuration
- ICACHE_MISS_MERGE_EN defined: address comparison across entries and same-cycle response bypass as described.
- Undefined: no comparators; every miss allocates its own entry and issues its own L2 request. The wake bitmap is always one-hot.

## Structure
- Shared package defines: imq_entry_idx_t, cache_line_addr_t (LINE_ADDR_WIDTH), and the imq_entry_t struct (valid, sent, addr, threads).
- Reuse the existing rr_arbiter and oh_to_idx modules. No new sub-module is needed.

## Test plan
- Single miss: thread 1 misses 0x12345 at N, ready held high → req valid at N+1 (addr 0x12345, id 0). Response id 0 at M → wake=4'b0010 at M+1.
- Merge: threads 0 and 2 miss 0x00040 on consecutive cycles, ready low → one request only. Response → wake=4'b0101.
- Backpressure: ready low for 10 cycles → addr and id stable and valid held. Ready high → accepted in that cycle; second pending entry presented on the next cycle.
- Bypass: thread 3 misses 0x00777 in the same cycle as the response for the entry holding 0x00777 (thread 0) → wake=4'b1001 and no new request.
- Four distinct-line misses → imq_full=1 and requests issued in round-robin order. Out-of-order responses (ids 2,0,3,1) → correct one-hot wakes.
- Reset asserted while req valid and 2 entries pending → all outputs 0 immediately. No request or wake after release.
